// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU definitions for the inter-stage pipeline registers: the reset and
// handler PC values, the exception codes, the stage payload widths, and the
// per-cycle operation the stage register performs.
package pipe_stage_reg_pkg;

  // PC loaded on reset (boot vector) and on flush (exception handler entry)
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FLUSH_PC = 32'h0000_4180;

  // Exception codes carried through the pipe; the stage register never
  // interprets them, it only forwards or clears them
  localparam int          EXC_CODE_W = 5;
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_INT    = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [4:0]  EXC_ADES   = 5'd5;
  localparam logic [4:0]  EXC_RI     = 5'd10;
  localparam logic [4:0]  EXC_OV     = 5'd12;

  // Payload widths of the individual stage boundaries; callers pack the
  // instruction word, operands and control bits into one vector
  localparam int INSTR_W      = 32;
  localparam int FD_DATA_W    = 32;
  localparam int DE_DATA_W    = 64;
  localparam int EM_DATA_W    = 64;
  localparam int MW_DATA_W    = 64;
  localparam int STAGE_DATA_W = 64;
  localparam int STALL_CNT_W  = 16;

  // What the stage register does on the next edge (reset is handled apart,
  // since it also clears the stall counter)
  typedef enum logic [1:0] {
    STAGE_HOLD   = 2'd0,
    STAGE_LOAD   = 2'd1,
    STAGE_BUBBLE = 2'd2,
    STAGE_FLUSH  = 2'd3
  } stage_op_e;

  // Flush beats bubble, bubble beats advance; with none of them the stage holds
  function automatic stage_op_e decode_stage_op(input logic flush,
                                                input logic bubble,
                                                input logic en);
    stage_op_e op;
    if (flush)       op = STAGE_FLUSH;
    else if (bubble) op = STAGE_BUBBLE;
    else if (en)     op = STAGE_LOAD;
    else             op = STAGE_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used to measure how long a stage holds a valid
// instruction. It sticks at all-ones instead of wrapping, so a long stall
// never reads back as a short one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic at_max;

  // Saturation detect: the counter is full when every bit is set
  always_comb begin
    at_max = &q;
  end

  // Count register: synchronous active-low reset, then clear, then increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W). Carries payload, PC,
// branch-delay flag and exception code with stall, flush and bubble support.
// A bubble keeps the PC/BD of the instruction that was held back, so CP0
// reports the right EPC/BD when an interrupt is taken on the bubble.
module pipe_stage_reg #(
  parameter int              DATA_W   = 64,
  parameter int              PC_W     = 32,
  parameter int              EXC_W    = 5,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(pipe_stage_reg_pkg::RESET_PC),
  parameter logic [PC_W-1:0] FLUSH_PC = PC_W'(pipe_stage_reg_pkg::FLUSH_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_stage_reg_pkg::*;

  stage_op_e stage_op;
  logic      hold_valid;

  // Decode this cycle's operation and whether it is a stall on a real instruction
  always_comb begin
    stage_op   = decode_stage_op(flush, bubble, en);
    hold_valid = (stage_op == STAGE_HOLD) && out_valid;
  end

  // All stage fields: reset, then flush, bubble, load, otherwise hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= RESET_PC;
      out_bd    <= 1'b0;
      out_exc   <= '0;
    end else begin
      unique case (stage_op)
        STAGE_FLUSH: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_pc    <= FLUSH_PC;
          out_bd    <= 1'b0;
          out_exc   <= '0;
        end
        STAGE_BUBBLE: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_pc    <= in_pc;
          out_bd    <= in_bd;
          out_exc   <= '0;
        end
        STAGE_LOAD: begin
          out_valid <= in_valid;
          out_data  <= in_data;
          out_pc    <= in_pc;
          out_bd    <= in_bd;
          out_exc   <= in_valid ? in_exc : '0;
        end
        default: begin
          out_valid <= out_valid;
          out_data  <= out_data;
          out_pc    <= out_pc;
          out_bd    <= out_bd;
          out_exc   <= out_exc;
        end
      endcase
    end
  end

  // Stall-cycle counter; only reset clears it, so flushes do not lose history
  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (hold_valid),
    .clr  (1'b0),
    .q    (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a wide-counter instance and a 3-bit-counter
// instance share one set of inputs. A behavioural model predicts the stage
// contents every cycle; literal expectations pin the model at key points.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        bubble;
  logic        in_valid;
  logic [63:0] in_data;
  logic [31:0] in_pc;
  logic        in_bd;
  logic [4:0]  in_exc;

  logic        out_valid;
  logic [63:0] out_data;
  logic [31:0] out_pc;
  logic        out_bd;
  logic [4:0]  out_exc;
  logic [15:0] stall_cnt;

  logic        s_valid;
  logic [63:0] s_data;
  logic [31:0] s_pc;
  logic        s_bd;
  logic [4:0]  s_exc;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  // expected stage contents
  bit          m_known = 0;
  logic        m_valid;
  logic [63:0] m_data;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  int          m_cnt;
  int          m_cnt3;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .out_valid(out_valid), .out_data(out_data),
    .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .out_valid(s_valid), .out_data(s_data),
    .out_pc(s_pc), .out_bd(s_bd), .out_exc(s_exc), .stall_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle, advance the model by the stage rules, compare at negedge
  task automatic applyStimulus(input logic rst_n, input logic e, input logic f,
                               input logic b, input logic v,
                               input logic [63:0] d, input logic [31:0] pc,
                               input logic bd, input logic [4:0] exc);
    reset = rst_n; en = e; flush = f; bubble = b;
    in_valid = v; in_data = d; in_pc = pc; in_bd = bd; in_exc = exc;
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1;
      m_valid = 0; m_data = 0; m_pc = 32'h3000; m_bd = 0; m_exc = 0;
      m_cnt = 0; m_cnt3 = 0;
    end else if (f) begin
      m_valid = 0; m_data = 0; m_pc = 32'h4180; m_bd = 0; m_exc = 0;
    end else if (b) begin
      m_valid = 0; m_data = 0; m_exc = 0; m_pc = pc; m_bd = bd;
    end else if (e) begin
      m_valid = v; m_data = d; m_pc = pc; m_bd = bd; m_exc = v ? exc : 5'd0;
    end else if (m_valid) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
    end
    @(negedge clk);
    if (m_known) begin
      checkOutput("model.valid", 64'(out_valid), 64'(m_valid));
      checkOutput("model.data", out_data, m_data);
      checkOutput("model.pc", 64'(out_pc), 64'(m_pc));
      checkOutput("model.bd", 64'(out_bd), 64'(m_bd));
      checkOutput("model.exc", 64'(out_exc), 64'(m_exc));
      checkOutput("model.cnt", 64'(stall_cnt), 64'(m_cnt));
      checkOutput("model.cnt3", 64'(s_cnt), 64'(m_cnt3));
      checkOutput("model.small_pc", 64'(s_pc), 64'(m_pc));
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1, 0, 0, 0, 1, 64'h1234, 32'h9990, 1, 5'd12);
  endtask

  initial begin
    reset = 0; en = 0; flush = 0; bubble = 0;
    in_valid = 0; in_data = 0; in_pc = 0; in_bd = 0; in_exc = 0;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    {32'($urandom), 32'($urandom)}, 32'($urandom),
                    1'($urandom), 5'($urandom));
    checkOutput("reset.valid", 64'(out_valid), 64'h0);
    checkOutput("reset.pc", 64'(out_pc), 64'h3000);
    checkOutput("reset.bd", 64'(out_bd), 64'h0);
    checkOutput("reset.exc", 64'(out_exc), 64'h0);
    checkOutput("reset.cnt", 64'(stall_cnt), 64'h0);

    // plain advance
    applyStimulus(1, 1, 0, 0, 1, 64'hDEAD, 32'h3004, 1, 5'd0);
    checkOutput("load.valid", 64'(out_valid), 64'h1);
    checkOutput("load.data", out_data, 64'hDEAD);
    checkOutput("load.pc", 64'(out_pc), 64'h3004);
    checkOutput("load.bd", 64'(out_bd), 64'h1);
    applyStimulus(1, 1, 0, 0, 0, 64'hBEEF, 32'h3008, 0, 5'd4);
    checkOutput("invalid.exc", 64'(out_exc), 64'h0);
    checkOutput("invalid.valid", 64'(out_valid), 64'h0);
    applyStimulus(1, 1, 0, 0, 1, 64'h77, 32'h300C, 0, 5'd10);
    checkOutput("valid.exc", 64'(out_exc), 64'd10);

    // stall on a valid instruction
    applyStimulus(1, 1, 0, 0, 1, 64'h5555, 32'h3010, 0, 5'd0);
    hold(5);
    checkOutput("stall.pc", 64'(out_pc), 64'h3010);
    checkOutput("stall.data", out_data, 64'h5555);
    checkOutput("stall.cnt5", 64'(stall_cnt), 64'd5);
    hold(5);
    checkOutput("stall.cnt10", 64'(stall_cnt), 64'd10);
    checkOutput("stall.sat3", 64'(s_cnt), 64'd7);

    // bubble overrides en, keeps incoming PC/BD
    applyStimulus(1, 1, 0, 1, 1, 64'hFFFF, 32'h3020, 1, 5'd5);
    checkOutput("bubble.valid", 64'(out_valid), 64'h0);
    checkOutput("bubble.data", out_data, 64'h0);
    checkOutput("bubble.exc", 64'(out_exc), 64'h0);
    checkOutput("bubble.pc", 64'(out_pc), 64'h3020);
    checkOutput("bubble.bd", 64'(out_bd), 64'h1);

    // flush beats bubble and en
    applyStimulus(1, 1, 0, 0, 1, 64'hAAAA, 32'h3030, 1, 5'd4);
    applyStimulus(1, 1, 1, 1, 1, 64'hBBBB, 32'h3034, 1, 5'd12);
    checkOutput("flush.valid", 64'(out_valid), 64'h0);
    checkOutput("flush.pc", 64'(out_pc), 64'h4180);
    checkOutput("flush.bd", 64'(out_bd), 64'h0);
    checkOutput("flush.exc", 64'(out_exc), 64'h0);
    checkOutput("flush.cnt", 64'(stall_cnt), 64'd10);
    hold(2);
    checkOutput("idle_hold.cnt", 64'(stall_cnt), 64'd10);

    // reset in the middle of a stall
    applyStimulus(1, 1, 0, 0, 1, 64'hCCCC, 32'h3040, 0, 5'd0);
    hold(3);
    checkOutput("stall3.cnt", 64'(stall_cnt), 64'd13);
    applyStimulus(0, 0, 0, 0, 1, 64'hDDDD, 32'h3050, 1, 5'd4);
    checkOutput("midreset.cnt", 64'(stall_cnt), 64'd0);
    checkOutput("midreset.valid", 64'(out_valid), 64'h0);
    checkOutput("midreset.pc", 64'(out_pc), 64'h3000);
    checkOutput("midreset.cnt3", 64'(s_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
